// File: rtl/game_flow_controller_pkg.sv
// Shared types and defaults for the game sequencer and the score counter it drives.
package game_flow_controller_pkg;

    // Phase seen by the score counter.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;

    // Internal sequencer phase; several of these map onto one state_t.
    typedef enum logic [2:0] {
        CS_READY     = 3'd0,
        CS_COUNTDOWN = 3'd1,
        CS_RUN       = 3'd2,
        CS_HIT_HOLD  = 3'd3,
        CS_PAUSE     = 3'd4,
        CS_WIN       = 3'd5,
        CS_DONE      = 3'd6
    } ctrl_state_t;

    localparam int TICK_CYCLES_12MHZ     = 12_000_000;
    localparam int HIT_HOLD_CYCLES_12MHZ = 6_000_000;
    localparam int COUNT_SECS_DEFAULT    = 3;
    localparam int WIN_SCORE_DEFAULT     = 99;

    // Pause presents OVER so the score counter freezes score and BCD digits.
    function automatic state_t present_state(input ctrl_state_t cs);
        present_state = OVER;
        case (cs)
            CS_READY, CS_COUNTDOWN: present_state = IDLE;
            CS_RUN, CS_HIT_HOLD:    present_state = RUN;
            CS_WIN:                 present_state = WIN;
            default:                present_state = OVER;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Button/collision/score inputs and phase outputs of the game sequencer.
interface game_flow_controller_if;
    import game_flow_controller_pkg::*;

    logic       start_i;
    logic       pause_i;
    logic       collision_i;
    logic [6:0] score_i;
    state_t     state_o;
    logic       collision_o;
    logic [1:0] countdown_o;
    logic       paused_o;
    logic       hit_hold_o;

    // Side that supplies buttons/score and watches the phase.
    modport master (
        output start_i, pause_i, collision_i, score_i,
        input  state_o, collision_o, countdown_o, paused_o, hit_hold_o
    );

    // The sequencer itself.
    modport slave (
        input  start_i, pause_i, collision_i, score_i,
        output state_o, collision_o, countdown_o, paused_o, hit_hold_o
    );
endinterface

// File: rtl/rise_edge_detect.sv
// Rising-edge detector against a one-cycle delayed copy. A level already high
// when reset releases is not an edge: the input must be seen low first.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic d_q;
    logic armed_q;

    // Delay register plus "seen low since reset" flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, regardless of statement order.
            d_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            d_q     <= d;
            armed_q <= armed_q | ~d;
        end
    end

    assign pulse = d & ~d_q & armed_q;
endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: ready -> 3-2-1 countdown -> run -> win/over, with pause
// and a post-collision grace window. Drives the score counter's phase input.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int TICK_CYCLES     = TICK_CYCLES_12MHZ,
    parameter int COUNT_SECS      = COUNT_SECS_DEFAULT,
    parameter int HIT_HOLD_CYCLES = HIT_HOLD_CYCLES_12MHZ,
    parameter int WIN_SCORE       = WIN_SCORE_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    game_flow_controller_if.slave bus
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HOLD_W = (HIT_HOLD_CYCLES > 1) ? $clog2(HIT_HOLD_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HIT_HOLD_CYCLES - 1);
    localparam logic [1:0]        COUNT_INIT = 2'(COUNT_SECS);
    localparam logic [6:0]        WIN_THRESH = 7'(WIN_SCORE);

    logic start_edge, pause_edge, coll_edge;

    rise_edge_detect u_start_edge (.clk(clk), .reset(reset), .d(bus.start_i),     .pulse(start_edge));
    rise_edge_detect u_pause_edge (.clk(clk), .reset(reset), .d(bus.pause_i),     .pulse(pause_edge));
    rise_edge_detect u_coll_edge  (.clk(clk), .reset(reset), .d(bus.collision_i), .pulse(coll_edge));

    ctrl_state_t       ctrl_q, ctrl_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        count_q, count_d;
    logic              coll_d;
    state_t            state_q;
    logic              coll_q, paused_q, hit_hold_q;

    // State, counters and all outputs update on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= CS_READY;
            tick_q     <= '0;
            hold_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            coll_q     <= 1'b0;
            paused_q   <= 1'b0;
            hit_hold_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tick_q     <= tick_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            state_q    <= present_state(ctrl_d);
            coll_q     <= coll_d;
            paused_q   <= (ctrl_d == CS_PAUSE);
            hit_hold_q <= (ctrl_d == CS_HIT_HOLD);
        end
    end

    // Next-state, counter and collision-pulse decode.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        ctrl_d  = ctrl_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        count_d = count_q;
        coll_d  = 1'b0;
        case (ctrl_q)
            CS_READY: begin
                if (start_edge) begin
                    ctrl_d  = CS_COUNTDOWN;
                    count_d = COUNT_INIT;
                    tick_d  = '0;
                end
            end
            CS_COUNTDOWN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (count_q == 2'd1) begin
                        ctrl_d  = CS_RUN;
                        count_d = 2'd0;
                    end else begin
                        count_d = count_q - 2'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            CS_RUN: begin
                if (bus.score_i == 7'd0) begin
                    ctrl_d = CS_DONE;
                end else if (bus.score_i >= WIN_THRESH) begin
                    ctrl_d = CS_WIN;
                end else if (pause_edge) begin
                    ctrl_d = CS_PAUSE;
                end else if (coll_edge) begin
                    ctrl_d = CS_HIT_HOLD;
                    coll_d = 1'b1;
                    hold_d = '0;
                end
            end
            CS_HIT_HOLD: begin
                if (bus.score_i == 7'd0) begin
                    ctrl_d = CS_DONE;
                end else if (bus.score_i >= WIN_THRESH) begin
                    ctrl_d = CS_WIN;
                end else if (hold_q == HOLD_LAST) begin
                    ctrl_d = CS_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            CS_PAUSE: begin
                // Quit beats resume when both buttons rise together.
                if (start_edge) begin
                    ctrl_d = CS_READY;
                end else if (pause_edge) begin
                    ctrl_d = CS_RUN;
                end
            end
            CS_WIN, CS_DONE: begin
                if (start_edge) begin
                    ctrl_d  = CS_COUNTDOWN;
                    count_d = COUNT_INIT;
                    tick_d  = '0;
                end
            end
            default: ctrl_d = CS_READY;
        endcase
    end

    assign bus.state_o     = state_q;
    assign bus.collision_o = coll_q;
    assign bus.countdown_o = count_q;
    assign bus.paused_o    = paused_q;
    assign bus.hit_hold_o  = hit_hold_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Scenario bench for game_flow_controller with short timing parameters.
module tb_game_flow_controller;
    import game_flow_controller_pkg::*;

    localparam int TB_TICK = 4;
    localparam int TB_SECS = 3;
    localparam int TB_HOLD = 5;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    game_flow_controller_if bus ();

    game_flow_controller #(
        .TICK_CYCLES    (TB_TICK),
        .COUNT_SECS     (TB_SECS),
        .HIT_HOLD_CYCLES(TB_HOLD),
        .WIN_SCORE      (99)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1);
    end

    // Expected output vector {state, collision, countdown, paused, hit_hold}.
    function automatic logic [6:0] mk(input state_t s, input logic c, input logic [1:0] cd,
                                      input logic p, input logic h);
        return {s, c, cd, p, h};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.state_o, bus.collision_o, bus.countdown_o, bus.paused_o, bus.hit_hold_o};
    endfunction

    // Expected output k cycles after entering the countdown: 3,2,1 then RUN.
    function automatic logic [6:0] cd_exp(input int k);
        if (k < TB_SECS * TB_TICK)
            return mk(IDLE, 1'b0, 2'(TB_SECS - k / TB_TICK), 1'b0, 1'b0);
        return mk(RUN, 1'b0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic drive(input logic st, input logic pa, input logic co, input logic [6:0] sc);
        bus.start_i     = st;
        bus.pause_i     = pa;
        bus.collision_i = co;
        bus.score_i     = sc;
    endtask

    task automatic test_reset();
        logic [6:0] want;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'd10);
        repeat (2) @(posedge clk);
        #1;
        want = mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== want) $display("FAIL reset_state: got %b want %b", obs(), want);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_countdown();
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(i == 10, i == 13, i == 16, 7'd10);
            sb.push_back('{"countdown", (i + 1 <= 10) ? mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0)
                                                       : cd_exp(i + 1 - 11)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, i + 1, obs(), e.v);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic co, hold, pulse;
        int   c;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            co = (i >= 2 && i <= 21) || i == 24 || i == 25 || i == 27 ||
                 i == 32 || i == 33 || i == 37 || i == 38;
            drive(1'b0, 1'b0, co, 7'd10);
            c     = i + 1;
            hold  = (c >= 3 && c <= 7) || (c >= 25 && c <= 29) || (c >= 33 && c <= 37);
            pulse = (c == 3) || (c == 25) || (c == 33);
            sb.push_back('{"collision", mk(RUN, pulse, 2'd0, 1'b0, hold)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
    endtask

    task automatic test_game_over();
        exp_t       e;
        logic [6:0] sc, want;
        int         c;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sc = (i < 3) ? 7'd1 : (i < 6) ? 7'd0 : 7'd10;
            drive(i == 1 || i == 6, 1'b0, i == 3 || i == 4, sc);
            c = i + 1;
            if (c <= 3)      want = mk(RUN, 1'b0, 2'd0, 1'b0, 1'b0);
            else if (c <= 6) want = mk(OVER, 1'b0, 2'd0, 1'b0, 1'b0);
            else             want = cd_exp(c - 7);
            sb.push_back('{"game_over", want});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
    endtask

    task automatic test_win();
        exp_t       e;
        logic [6:0] sc, want;
        int         c;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            sc = (i == 2) ? 7'd98 : (i >= 3 && i < 8) ? 7'd99 : 7'd10;
            drive(i == 9, i == 2 || i == 6, i == 1 || i == 2, sc);
            c = i + 1;
            if (c == 1)       want = mk(RUN, 1'b0, 2'd0, 1'b0, 1'b0);
            else if (c == 2)  want = mk(RUN, 1'b1, 2'd0, 1'b0, 1'b1);
            else if (c == 3)  want = mk(RUN, 1'b0, 2'd0, 1'b0, 1'b1);
            else if (c <= 9)  want = mk(WIN, 1'b0, 2'd0, 1'b0, 1'b0);
            else              want = cd_exp(c - 10);
            sb.push_back('{"win", want});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        exp_t       e;
        logic [6:0] want;
        int         c;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(i == 11, i == 1 || i == 5 || i == 8 || i == 11, i == 3 || i == 4, 7'd10);
            c = i + 1;
            if (c <= 1)       want = mk(RUN, 1'b0, 2'd0, 1'b0, 1'b0);
            else if (c <= 5)  want = mk(OVER, 1'b0, 2'd0, 1'b1, 1'b0);
            else if (c <= 8)  want = mk(RUN, 1'b0, 2'd0, 1'b0, 1'b0);
            else if (c <= 11) want = mk(OVER, 1'b0, 2'd0, 1'b1, 1'b0);
            else              want = mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0);
            sb.push_back('{"pause", want});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [6:0] want;
        int         c;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(i == 1, 1'b0, 1'b0, 7'd10);
            c = i + 1;
            want = (c <= 1) ? mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0) : cd_exp(c - 2);
            sb.push_back('{"pre_reset", want});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
        // Countdown shows 2 here; reset asserts away from any clock edge.
        @(negedge clk);
        reset = 1'b0;
        bus.start_i = 1'b1;
        #1;
        want = mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== want) $display("FAIL async_reset: got %b want %b", obs(), want);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(!(i == 5 || i == 6), 1'b0, 1'b0, 7'd10);
            c = i + 1;
            want = (c <= 7) ? mk(IDLE, 1'b0, 2'd0, 1'b0, 1'b0) : cd_exp(c - 8);
            sb.push_back('{"post_reset_start", want});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs() !== e.v) $display("FAIL %s cycle %0d: got %b want %b", e.tag, c, obs(), e.v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_collision();
        test_game_over();
        test_win();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer that drives the `state` input of the score counter.
- Runs the game phases ready → 3-2-1 countdown → run → win/over, plus pause and a post-collision grace window.
- Qualifies raw collision events into single-cycle pulses so a single hit costs exactly one point; ignores hits during the grace window.
- Watches the registered score: 0 ends the game (OVER), WIN_SCORE ends it as WIN.

Parameters:
- TICK_CYCLES, 12_000_000, clk cycles per countdown second (12 MHz system clock).
- COUNT_SECS, 3, countdown length in seconds; range 1..3.
- HIT_HOLD_CYCLES, 6_000_000, grace window after a qualified collision (0.5 s).
- WIN_SCORE, 99, score at or above which the game is won.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  start button, clean synchronous level.
- pause_i  in  1  pause button, clean synchronous level.
- collision_i  in  1  raw collision level from the object/collision logic.
- score_i  in  7  registered score from the score counter.
- state_o  out  state_t  phase presented to the score counter (IDLE/RUN/WIN/OVER).
- collision_o  out  1  qualified one-cycle collision pulse to the score counter.
- countdown_o  out  2  digit currently being shown (3,2,1); 0 outside countdown.
- paused_o  out  1  high while in PAUSE.
- hit_hold_o  out  1  high during the grace window (display blink).

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - Internal state READY.
  - state_o=IDLE, collision_o=0, countdown_o=0, paused_o=0, hit_hold_o=0.
  - All counters and edge registers 0.
- Output timing: all outputs are registered and change on the same edge as the internal state.
- Edge detection: start, pause and collision use rising-edge detection against a 1-cycle delayed copy. An edge seen in cycle N takes effect at edge N+1.
- Internal ctrl_state_t, with the state_o each state presents:
  - READY → IDLE.
  - COUNTDOWN → IDLE (holds score at 10).
  - RUN → RUN.
  - HIT_HOLD → RUN.
  - PAUSE → OVER (OVER freezes the score and BCD outputs).
  - WIN → WIN.
  - DONE → OVER.
- READY: start edge → COUNTDOWN. On entry: countdown_o=COUNT_SECS, tick counter=0.
- COUNTDOWN:
  - Tick counter counts 0..TICK_CYCLES-1.
  - At terminal count: counter wraps to 0 and countdown_o decrements.
  - Terminal count with countdown_o==1 → RUN, countdown_o=0.
  - Total duration is exactly COUNT_SECS*TICK_CYCLES cycles.
  - start, pause and collision are ignored.
- RUN: evaluate per cycle in this priority order.
  1. score_i==0 → DONE.
  2. score_i>=WIN_SCORE → WIN.
  3. pause edge → PAUSE.
  4. collision edge → HIT_HOLD, with collision_o=1 for exactly one cycle and the hold counter cleared.
  - start is ignored.
- HIT_HOLD:
  - collision_o held 0; all collisions ignored, including a new edge on the exit cycle.
  - The score_i==0 and WIN checks apply, with the same priority as RUN.
  - Pause edge is ignored.
  - After HIT_HOLD_CYCLES cycles → RUN.
  - A collision level still high on exit does not generate an edge.
- PAUSE:
  - pause edge → RUN.
  - start edge → READY (quit).
  - Collisions ignored; score frozen via OVER.
- WIN and DONE: terminal; start edge → COUNTDOWN (a restart passes through IDLE, so the score reloads to 10).
- Simultaneous events: start and pause edges in the same cycle in PAUSE → start wins (READY).
- collision_o is never asserted outside RUN, so there is no underflow past 0 (score 0 → DONE next cycle).
- Reset mid-operation: immediate return to the reset values above; no pulse is generated on release, even if inputs are already high (the edge registers clear to 0, and the first sampled high is an edge only if it arrives after release).
- Counter widths: $clog2 of each cycle parameter; comparisons are unsigned.

Decomposition:
- Shared package additions:
  - state_t (IDLE, RUN, WIN, OVER), already used by the score counter.
  - New ctrl_state_t.
  - Default constants TICK_CYCLES_12MHZ, WIN_SCORE_DEFAULT.
- Sub-module rise_edge_detect (clk, reset, d → pulse), instantiated three times.

Test Plan:
- Run with TICK_CYCLES=4, COUNT_SECS=3, HIT_HOLD_CYCLES=5 for all scenarios.
- Countdown: reset release, start pulse at cycle 10 → COUNTDOWN from cycle 11; countdown_o 3,2,1 for 4 cycles each; state_o=IDLE throughout; RUN at cycle 23 with countdown_o=0.
- Collision qualification: in RUN, collision_i held high 20 cycles → exactly one collision_o pulse, one cycle after the rise; hit_hold_o high 5 cycles. A second rise during hold → no pulse. A new rise after hold exit → one pulse.
- Game over: in RUN, score_i driven 1→0 → state_o=OVER next cycle. A simultaneous collision edge gives no collision_o. start edge → IDLE for the 12 countdown cycles, then RUN.
- Win: score_i=98 then 99 while in HIT_HOLD → WIN next cycle; hit_hold_o=0; pause edges ignored.
- Pause: pause edge in RUN → state_o=OVER, paused_o=1; a collision edge gives no pulse; pause edge again → RUN. Start and pause edges in the same cycle in PAUSE → READY/IDLE.
- Reset mid-countdown: reset low at countdown_o=2 → all outputs return to reset values asynchronously. Release with start_i already high → stays READY until start falls and rises again.
